// File: rtl/regfile_ckpt_sb.sv
// Multi-port integer register file with write bypass,
// busy scoreboard and one-deep branch checkpoint.
module regfile_ckpt_sb #(
    parameter int NREGS       = 32,
    parameter int DW          = 64,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int BYPASS      = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [READ_PORTS*AW-1:0]  ra_a,
    input  logic [READ_PORTS*AW-1:0]  ra_b,
    output logic [READ_PORTS*DW-1:0]  rd_a,
    output logic [READ_PORTS*DW-1:0]  rd_b,
    output logic [READ_PORTS-1:0]     busy_a,
    output logic [READ_PORTS-1:0]     busy_b,
    input  logic [WRITE_PORTS*AW-1:0] wa,
    input  logic [WRITE_PORTS-1:0]    wvalid,
    input  logic [WRITE_PORTS*DW-1:0] wd,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_rd,
    input  logic                      ckpt_save,
    input  logic                      ckpt_restore,
    output logic                      ckpt_valid
);

    logic [DW-1:0]    regs     [NREGS];
    logic [DW-1:0]    regs_nxt [NREGS];
    logic [DW-1:0]    snap     [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             do_restore;
    logic             do_save;

    assign do_restore = ckpt_restore && ckpt_valid;
    assign do_save    = ckpt_save && !ckpt_restore;

    // Later write ports override earlier ones on the same register.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_nxt[i] = regs[i];
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && wa[j*AW +: AW] == AW'(i)) begin
                    regs_nxt[i] = wd[j*DW +: DW];
                end
            end
        end
        regs_nxt[0] = '0;
    end

    // Issue is applied after writeback clears so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < WRITE_PORTS; j++) begin
            if (wvalid[j]) begin
                busy_nxt[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        busy_a = '0;
        busy_b = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (BYPASS != 0) begin
                rd_a[p*DW +: DW] = regs_nxt[ra_a[p*AW +: AW]];
                rd_b[p*DW +: DW] = regs_nxt[ra_b[p*AW +: AW]];
            end else begin
                rd_a[p*DW +: DW] = regs[ra_a[p*AW +: AW]];
                rd_b[p*DW +: DW] = regs[ra_b[p*AW +: AW]];
            end
            busy_a[p] = busy[ra_a[p*AW +: AW]];
            busy_b[p] = busy[ra_b[p*AW +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                snap[i] <= '0;
            end
            busy       <= '0;
            ckpt_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= do_restore ? snap[i] : regs_nxt[i];
                if (do_save) begin
                    snap[i] <= regs_nxt[i];
                end
            end
            busy <= ckpt_restore ? '0 : busy_nxt;
            if (do_save) begin
                ckpt_valid <= 1'b1;
            end else if (do_restore) begin
                ckpt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_ckpt_sb.sv
// Directed bench for regfile_ckpt_sb: two write ports,
// bypass enabled, hand-computed expectations.
module tb_regfile_ckpt_sb;

    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    ra_a, ra_b;
    logic [127:0]  rd_a, rd_b;
    logic [1:0]    busy_a, busy_b;
    logic [9:0]    wa;
    logic [1:0]    wvalid;
    logic [127:0]  wd;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic          ckpt_save, ckpt_restore;
    logic          ckpt_valid;

    int vectors = 0;
    int errors  = 0;

    regfile_ckpt_sb #(
        .NREGS(32), .DW(DW), .READ_PORTS(2),
        .WRITE_PORTS(2), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(rd_a), .rd_b(rd_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wa(wa), .wvalid(wvalid), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .ckpt_valid(ckpt_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wvalid       = '0;
        wa           = '0;
        wd           = '0;
        iss_valid    = 1'b0;
        iss_rd       = '0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        ra_a = '0;
        ra_b = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_ckpt_valid", 64'(ckpt_valid), 64'd0);
        for (int r = 0; r < 32; r++) begin
            ra_a = {5'(r), 5'(31 - r)};
            ra_b = {5'(31 - r), 5'(r)};
            #1;
            chk("reset_rd_a0", rd_a[63:0], 64'd0);
            chk("reset_rd_b1", rd_b[127:64], 64'd0);
            chk("reset_busy", 64'({busy_a, busy_b}), 64'd0);
        end
    endtask

    task automatic test_write_merge();
        idle();
        wa     = {5'd5, 5'd5};
        wd     = {64'hBB, 64'hAA};
        wvalid = 2'b11;
        ra_a   = {5'd0, 5'd5};
        ra_b   = {5'd5, 5'd0};
        #1;
        chk("merge_bypass_a0", rd_a[63:0], 64'hBB);
        chk("merge_bypass_b1", rd_b[127:64], 64'hBB);
        tick();
        idle();
        #1;
        chk("merge_stored", rd_a[63:0], 64'hBB);
        wa     = {5'd9, 5'd5};
        wd     = {64'h99, 64'hAA};
        wvalid = 2'b01;
        ra_a   = {5'd9, 5'd5};
        #1;
        chk("port0_only_bypass", rd_a[63:0], 64'hAA);
        chk("port1_invalid_9", rd_a[127:64], 64'h0);
        tick();
        idle();
        #1;
        chk("port0_stored", rd_a[63:0], 64'hAA);
        chk("port1_not_stored", rd_a[127:64], 64'h0);
    endtask

    task automatic test_reg0();
        idle();
        wa        = {5'd0, 5'd0};
        wd        = {64'hFF, 64'hFF};
        wvalid    = 2'b11;
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        ra_a      = {5'd0, 5'd0};
        #1;
        chk("reg0_bypass", rd_a[63:0], 64'h0);
        tick();
        idle();
        #1;
        chk("reg0_rd", rd_a[63:0], 64'h0);
        chk("reg0_busy", 64'(busy_a[0]), 64'd0);
    endtask

    task automatic test_scoreboard();
        idle();
        ra_a      = {5'd7, 5'd7};
        ra_b      = {5'd7, 5'd7};
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #1;
        chk("busy_no_bypass", 64'(busy_a[0]), 64'd0);
        tick();
        idle();
        #1;
        chk("busy_set_a", 64'(busy_a), 64'd3);
        chk("busy_set_b", 64'(busy_b), 64'd3);
        wa        = {5'd0, 5'd7};
        wvalid    = 2'b01;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        idle();
        #1;
        chk("set_wins", 64'(busy_a[0]), 64'd1);
        wa     = {5'd7, 5'd0};
        wvalid = 2'b10;
        tick();
        idle();
        #1;
        chk("busy_cleared", 64'(busy_a[0]), 64'd0);
    endtask

    task automatic test_checkpoint();
        idle();
        ra_a   = {5'd9, 5'd3};
        ra_b   = {5'd4, 5'd3};
        wa     = {5'd0, 5'd3};
        wd     = {64'h0, 64'h11};
        wvalid = 2'b01;
        tick();
        idle();
        wa        = {5'd0, 5'd3};
        wd        = {64'h0, 64'h22};
        wvalid    = 2'b01;
        ckpt_save = 1'b1;
        tick();
        idle();
        #1;
        chk("save_valid", 64'(ckpt_valid), 64'd1);
        chk("save_rd3", rd_a[63:0], 64'h22);
        wa        = {5'd0, 5'd3};
        wd        = {64'h0, 64'h33};
        wvalid    = 2'b01;
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        tick();
        idle();
        #1;
        chk("post_save_rd3", rd_a[63:0], 64'h33);
        chk("busy4_set", 64'(busy_b[1]), 64'd1);
        ckpt_restore = 1'b1;
        wa           = {5'd0, 5'd3};
        wd           = {64'h0, 64'h44};
        wvalid       = 2'b01;
        iss_valid    = 1'b1;
        iss_rd       = 5'd9;
        #1;
        chk("restore_cycle_bypass", rd_a[63:0], 64'h44);
        tick();
        idle();
        #1;
        chk("restored_rd3", rd_a[63:0], 64'h22);
        chk("restored_busy4", 64'(busy_b[1]), 64'd0);
        chk("restore_drop_iss9", 64'(busy_a[1]), 64'd0);
        chk("restored_valid", 64'(ckpt_valid), 64'd0);
    endtask

    task automatic test_save_restore_same();
        idle();
        ra_a         = {5'd8, 5'd6};
        ckpt_save    = 1'b1;
        ckpt_restore = 1'b1;
        wa           = {5'd0, 5'd6};
        wd           = {64'h0, 64'h66};
        wvalid       = 2'b01;
        iss_valid    = 1'b1;
        iss_rd       = 5'd8;
        tick();
        idle();
        #1;
        chk("sr_valid", 64'(ckpt_valid), 64'd0);
        chk("sr_rd6", rd_a[63:0], 64'h66);
        chk("sr_busy8", 64'(busy_a[1]), 64'd0);
    endtask

    task automatic test_reset_mid();
        idle();
        ra_a      = {5'd6, 5'd3};
        ckpt_save = 1'b1;
        tick();
        idle();
        #1;
        chk("mid_saved", 64'(ckpt_valid), 64'd1);
        ckpt_restore = 1'b1;
        iss_valid    = 1'b1;
        iss_rd       = 5'd6;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mid_valid", 64'(ckpt_valid), 64'd0);
        chk("mid_rd3", rd_a[63:0], 64'h0);
        chk("mid_rd6", rd_a[127:64], 64'h0);
        chk("mid_busy6", 64'(busy_a[1]), 64'd0);
    endtask

    initial begin
        test_reset();
        test_write_merge();
        test_reg0();
        test_scoreboard();
        test_checkpoint();
        test_save_restore_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
